// File: rtl/lm07_poll_ctrl.sv
// lm07_poll_ctrl: LM07 SPI temperature sensor poller with on-demand reads.
// Optional over-temperature alarm is built only when LM07_ALARM_EN is defined.
module lm07_poll_ctrl #(
  parameter int CLKDIV      = 2,
  parameter int POLL_PERIOD = 1000,
  parameter int CS_IDLE     = 4
) (
  input  logic        SYSCLK,
  input  logic        RST,
  output logic        CS,
  output logic        SCK,
  input  logic        SIO,
  input  logic        rd_req,
  output logic        busy,
  output logic [15:0] raw,
  output logic [12:0] temp,
  output logic        valid,
  output logic        rd_done,
  input  logic [12:0] thresh,
  output logic        alarm
);
  localparam int TW = $clog2(POLL_PERIOD + 1);
  localparam int IW = $clog2(CS_IDLE + 2);
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [15:0] shift_q, shift_d, raw_q, raw_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] idl_q, idl_d;
  logic pend_q, pend_d, tag_q, tag_d;
  logic tick, expired, idle_ok, start, load;
  assign tick    = int'(cnt_q) == CLKDIV - 1;
  assign expired = int'(tmr_q) >= POLL_PERIOD - 1;
  // counts the current cycle too, since CS is already high during it
  assign idle_ok = int'(idl_q) + 1 >= CS_IDLE;
  assign start   = state_q == IDLE && (pend_q || expired) && idle_ok;
  assign load    = state_q == SCK_LO && tick && bit_q == 4'd15;
  assign CS      = state_q == IDLE || state_q == DONE;
  assign SCK     = state_q == SCK_HI;
  assign busy    = ~CS;
  assign valid   = state_q == DONE;
  assign rd_done = state_q == DONE && tag_q;
  assign raw     = raw_q;
  assign temp    = raw_q[15:3];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = tick ? SCK_HI : SETUP;
      SCK_HI:  state_d = tick ? SCK_LO : SCK_HI;
      SCK_LO:  state_d = tick ? (bit_q == 4'd15 ? DONE : SCK_HI) : SCK_LO;
      default: state_d = IDLE;
    endcase
    cnt_d   = (CS || tick) ? 8'd0 : cnt_q + 8'd1;
    bit_d   = state_q == SETUP ? 4'd0 : (state_q == SCK_LO && tick) ? bit_q + 4'd1 : bit_q;
    shift_d = (state_q == SCK_HI && cnt_q == 8'd0) ? {shift_q[14:0], SIO} : shift_q;
    raw_d   = load ? shift_q : raw_q;
    tmr_d   = state_q == DONE ? '0 : (state_q == IDLE && int'(tmr_q) < POLL_PERIOD) ? tmr_q + TW'(1) : tmr_q;
    idl_d   = CS ? ((int'(idl_q) < CS_IDLE) ? idl_q + IW'(1) : idl_q) : '0;
    pend_d  = rd_req | (pend_q & ~rd_done);
    tag_d   = start ? pend_q : tag_q;
  end
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      raw_q   <= '0;
      tmr_q   <= '0;
      idl_q   <= IW'(CS_IDLE);
      pend_q  <= 1'b0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      raw_q   <= raw_d;
      tmr_q   <= tmr_d;
      idl_q   <= idl_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
    end
  end
`ifdef LM07_ALARM_EN
  logic alarm_q, alarm_d;
  assign alarm_d = load ? ($signed(shift_q[15:3]) >= $signed(thresh)) : alarm_q;
  always_ff @(posedge SYSCLK) alarm_q <= RST ? 1'b0 : alarm_d;
  assign alarm = alarm_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_lm07_poll_ctrl.sv
// tb_lm07_poll_ctrl: directed vectors for lm07_poll_ctrl with a behavioural LM07 sensor model.
module tb_lm07_poll_ctrl;
  logic clk = 0, rst = 1, sel = 0;
  logic rd_a = 0, rd_b = 0;
  logic [12:0] thr = '0;
  logic [15:0] word = 16'h0B9F;
  logic cs_a, sck_a, sio_a, busy_a, valid_a, done_a, alarm_a;
  logic cs_b, sck_b, sio_b, busy_b, valid_b, done_b, alarm_b;
  logic [15:0] raw_a, raw_b;
  logic [12:0] temp_a, temp_b;
  logic [3:0] idx_a = 0, idx_b = 0;
  logic prev_a = 0, prev_b = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  lm07_poll_ctrl #(.CLKDIV(2), .POLL_PERIOD(100), .CS_IDLE(4)) dut_a (
    .SYSCLK(clk), .RST(rst), .CS(cs_a), .SCK(sck_a), .SIO(sio_a), .rd_req(rd_a),
    .busy(busy_a), .raw(raw_a), .temp(temp_a), .valid(valid_a), .rd_done(done_a),
    .thresh(thr), .alarm(alarm_a));
  lm07_poll_ctrl #(.CLKDIV(1), .POLL_PERIOD(50), .CS_IDLE(2)) dut_b (
    .SYSCLK(clk), .RST(rst), .CS(cs_b), .SCK(sck_b), .SIO(sio_b), .rd_req(rd_b),
    .busy(busy_b), .raw(raw_b), .temp(temp_b), .valid(valid_b), .rd_done(done_b),
    .thresh(thr), .alarm(alarm_b));

  // sensor: presents bit (15 - number of SCK falling edges seen while CS low)
  always @(posedge clk) begin
    idx_a <= cs_a ? 4'd0 : (prev_a && !sck_a) ? idx_a + 4'd1 : idx_a;
    idx_b <= cs_b ? 4'd0 : (prev_b && !sck_b) ? idx_b + 4'd1 : idx_b;
    prev_a <= sck_a;
    prev_b <= sck_b;
  end
  assign sio_a = word[4'd15 - idx_a];
  assign sio_b = word[4'd15 - idx_b];

  logic cs_m, sck_m, busy_m, valid_m, done_m, alarm_m;
  logic [15:0] raw_m;
  logic [12:0] temp_m;
  assign cs_m    = sel ? cs_b : cs_a;
  assign sck_m   = sel ? sck_b : sck_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign valid_m = sel ? valid_b : valid_a;
  assign done_m  = sel ? done_b : done_a;
  assign alarm_m = sel ? alarm_b : alarm_a;
  assign raw_m   = sel ? raw_b : raw_a;
  assign temp_m  = sel ? temp_b : temp_a;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_low(input int budget, output int w, output bit ok);
    w = 0;
    ok = 0;
    while (w < budget) begin
      if (!cs_m) begin
        ok = 1;
        break;
      end
      step();
      w++;
    end
  endtask

  task automatic finish(output int low, output int pulses, output int hi);
    bit prev;
    low = 0; pulses = 0; hi = 0; prev = 0;
    while (!cs_m && low < 300) begin
      if (sck_m) hi++;
      if (sck_m && !prev) pulses++;
      prev = sck_m;
      low++;
      step();
    end
  endtask

  task automatic pulse_rd();
    if (sel) rd_b = 1; else rd_a = 1;
    step();
    rd_a = 0;
    rd_b = 0;
  endtask

  typedef struct {
    logic [15:0] word;
    logic [12:0] thr;
    logic [15:0] raw;
    logic [12:0] temp;
    logic        alarm;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, low, pulses, hi;
    bit ok;
    logic exp_alarm;
    tbl[0] = '{16'h0B9F, 13'h0173, 16'h0B9F, 13'h0173, 1'b1};
    tbl[1] = '{16'h0B9F, 13'h0174, 16'h0B9F, 13'h0173, 1'b0};
    tbl[2] = '{16'hFFF8, 13'h1FFF, 16'hFFF8, 13'h1FFF, 1'b1};
    tbl[3] = '{16'h8000, 13'h0000, 16'h8000, 13'h1000, 1'b0};
    tbl[4] = '{16'h7FF8, 13'h0FFF, 16'h7FF8, 13'h0FFF, 1'b1};
    tbl[5] = '{16'h0007, 13'h1FFF, 16'h0007, 13'h0000, 1'b1};
    tbl[6] = '{16'h0C80, 13'h0190, 16'h0C80, 13'h0190, 1'b1};

    step(); step();
    chk("rst_cs", cs_m, 1);
    chk("rst_sck", sck_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_raw", raw_m, 0);
    chk("rst_valid", valid_m, 0);
    chk("rst_rd_done", done_m, 0);
    chk("rst_alarm", alarm_m, 0);

    rst = 0;
    pulse_rd();
    wait_low(20, w, ok);
    chk("first_start_ok", ok, 1);
    chk("first_start_lat", w, 1);
    finish(low, pulses, hi);
    chk("first_cs_low", low, 66);
    chk("first_pulses", pulses, 16);
    chk("first_sck_high", hi, 32);
    chk("first_raw", raw_m, 16'h0B9F);
    chk("first_temp", temp_m, 13'h0173);
    chk("first_valid", valid_m, 1);
    chk("first_rd_done", done_m, 1);

    for (int i = 0; i < 7; i++) begin
      word = tbl[i].word;
      thr = tbl[i].thr;
`ifdef LM07_ALARM_EN
      exp_alarm = tbl[i].alarm;
`else
      exp_alarm = 1'b0;
`endif
      pulse_rd();
      wait_low(20, w, ok);
      chk($sformatf("vec%0d_start", i), ok, 1);
      finish(low, pulses, hi);
      chk($sformatf("vec%0d_raw", i), raw_m, tbl[i].raw);
      chk($sformatf("vec%0d_temp", i), temp_m, tbl[i].temp);
      chk($sformatf("vec%0d_valid", i), valid_m, 1);
      chk($sformatf("vec%0d_rd_done", i), done_m, 1);
      chk($sformatf("vec%0d_alarm", i), alarm_m, exp_alarm);
    end
    word = 16'h0B9F;

    for (int k = 0; k < 2; k++) begin
      wait_low(300, w, ok);
      chk($sformatf("poll%0d_gap", k), w, 101);
      finish(low, pulses, hi);
      chk($sformatf("poll%0d_cs_low", k), low, 66);
      chk($sformatf("poll%0d_valid", k), valid_m, 1);
      chk($sformatf("poll%0d_rd_done", k), done_m, 0);
      chk($sformatf("poll%0d_raw", k), raw_m, 16'h0B9F);
    end

    wait_low(300, w, ok);
    chk("mid_poll_start", ok, 1);
    repeat (22) step();
    chk("mid_sck_bit5", sck_m, 1);
    pulse_rd();
    finish(low, pulses, hi);
    chk("mid_cur_valid", valid_m, 1);
    chk("mid_cur_rd_done", done_m, 0);
    wait_low(50, w, ok);
    chk("mid_next_gap", w, 4);
    finish(low, pulses, hi);
    chk("mid_next_valid", valid_m, 1);
    chk("mid_next_rd_done", done_m, 1);

    pulse_rd();
    wait_low(20, w, ok);
    chk("rstmid_start", ok, 1);
    repeat (34) step();
    chk("rstmid_sck_bit8", sck_m, 1);
    rst = 1;
    step();
    chk("rstmid_cs", cs_m, 1);
    chk("rstmid_sck", sck_m, 0);
    chk("rstmid_raw", raw_m, 0);
    chk("rstmid_valid", valid_m, 0);
    chk("rstmid_alarm", alarm_m, 0);
    step();
    rst = 0;
    pulse_rd();
    wait_low(20, w, ok);
    chk("rstmid_restart_lat", w, 1);
    finish(low, pulses, hi);
    chk("rstmid_cs_low", low, 66);
    chk("rstmid_raw_clean", raw_m, 16'h0B9F);
    chk("rstmid_rd_done", done_m, 1);

    sel = 1;
    rst = 1;
    step(); step();
    rst = 0;
    pulse_rd();
    wait_low(20, w, ok);
    chk("div1_start", ok, 1);
    finish(low, pulses, hi);
    chk("div1_cs_low", low, 33);
    chk("div1_pulses", pulses, 16);
    chk("div1_sck_high", hi, 16);
    chk("div1_raw", raw_m, 16'h0B9F);
    chk("div1_temp", temp_m, 13'h0173);
    chk("div1_rd_done", done_m, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lm07_poll_ctrl.md
LM07_POLL_CTRL -- requirements
Module: lm07_poll_ctrl

Interface
REQ-001 Parameter CLKDIV, default 2: SYSCLK cycles per SCK half-period; legal values are 1 to 255.
REQ-002 Parameter POLL_PERIOD, default 1000: SYSCLK cycles from end of one frame to the next automatic frame; legal values are 1 or more.
REQ-003 Parameter CS_IDLE, default 4: minimum SYSCLK cycles CS stays high between frames.
REQ-004 SYSCLK  input  1  system clock; all logic on its rising edge.
REQ-005 RST  input  1  reset, synchronous to SYSCLK, active-high.
REQ-006 CS  output  1  sensor chip select, active-low.
REQ-007 SCK  output  1  sensor serial clock, idles low.
REQ-008 SIO  input  1  sensor serial data, MSB first.
REQ-009 rd_req  input  1  on-demand read request; single-cycle pulse or level.
REQ-010 busy  output  1  high while a frame is in progress (CS low).
REQ-011 raw  output  16  last complete 16-bit word shifted in.
REQ-012 temp  output  13  raw[15:3], two's complement, 0.0625 C per LSB.
REQ-013 valid  output  1  one-cycle pulse when raw and temp update.
REQ-014 rd_done  output  1  one-cycle pulse, coincident with valid, on the frame that serves an rd_req.
REQ-015 thresh  input  13  signed over-temperature threshold.
REQ-016 alarm  output  1  over-temperature flag.

Function
REQ-017 FSM states: IDLE, SETUP, SCK_HI, SCK_LO, DONE.
REQ-018 IDLE: CS=1, SCK=0; start a frame when (rd pending or poll timer expired) and CS has been high for at least CS_IDLE cycles.
REQ-019 Start of frame: the FSM enters SETUP and CS goes low at the next SYSCLK edge; SETUP lasts CLKDIV cycles with SCK=0.
REQ-020 SCK_HI lasts CLKDIV cycles with SCK=1; SIO is sampled into bit (15 - n) on the first cycle of SCK_HI for bit n.
REQ-021 SCK_LO lasts CLKDIV cycles with SCK=0, during which the sensor shifts; after 16 high/low pairs the FSM goes to DONE.
REQ-022 DONE lasts 1 cycle: CS=1, raw and temp are loaded, valid pulses, and the poll timer restarts from 0.
REQ-023 Total CS-low time is CLKDIV*33 cycles (66 cycles at the default CLKDIV).
REQ-024 rd_req asserted in any cycle sets a pending flag; the pending flag is cleared and rd_done pulses only in DONE of a frame that started after the request was registered.
REQ-025 A request arriving mid-frame is served by the next frame, never by the current one.
REQ-026 When the poll timer and a pending request coincide, one frame serves both.
REQ-027 The poll timer saturates at POLL_PERIOD and is held (not counting) while busy.
REQ-028 busy = ~CS.

Reset
REQ-029 RST, including mid-frame, forces the following at the next edge: FSM to IDLE, CS=1, SCK=0, raw=0, temp=0, valid=0, rd_done=0, alarm=0, pending=0, poll timer=0.
REQ-030 The CS_IDLE counter is preloaded as satisfied after reset, so a pending request after reset starts a frame immediately.
REQ-031 After reset, the first automatic frame starts POLL_PERIOD cycles after RST deasserts.

Configuration
REQ-032 Macro LM07_ALARM_EN.
REQ-033 With LM07_ALARM_EN defined: in DONE, alarm is set if the new temp >= thresh (signed compare) and cleared if the new temp < thresh; alarm is held between frames.
REQ-034 Without LM07_ALARM_EN: alarm is tied to 0, thresh is ignored, and the comparator is not built.

Verification
REQ-035 Sensor model holds 0x0B9F; RST for 2 cycles, then a single-cycle rd_req -> CS low for 66 cycles, 16 SCK pulses, raw=0x0B9F, temp=0x173, valid and rd_done pulse together.
REQ-036 No rd_req, POLL_PERIOD=100 -> frames start every 100+66+1 cycles; valid pulses each frame; rd_done never pulses.
REQ-037 rd_req during bit 5 of a poll frame -> that frame ends without rd_done; a second frame starts CS_IDLE cycles later; rd_done pulses at its DONE.
REQ-038 RST asserted at bit 8 -> CS=1 and SCK=0 on the next edge; raw stays 0; the next frame returns a clean 0x0B9F.
REQ-039 LM07_ALARM_EN defined: thresh=0x173 -> alarm=1; thresh=0x174 -> alarm=0 after the next frame.
REQ-040 CLKDIV=1 -> SCK period is 2 cycles, CS-low time is 33 cycles, and raw=0x0B9F.
